divmod_seq: RTL and testbench
=============================

Name: divmod_seq

Overview:
- Parametrised sequential divider. Computes quotient and remainder of a / b, signed or unsigned, selected per operation.
- Uses a radix-2 restoring shift-subtract datapath and takes a fixed WIDTH iterations, instead of data-dependent repeated subtraction.
- Sits beside the ALU as a multi-cycle functional unit with a start/done handshake.
- Flags divide-by-zero explicitly.

Parameters:
WIDTH, 32, operand/result width in bits (legal range 4..64)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
CLK  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request; sampled only in IDLE
op_signed  in  1  1 = two's-complement operation, 0 = unsigned; sampled with start
a  in  WIDTH  dividend; sampled with start
b  in  WIDTH  divisor; sampled with start
busy  out  1  high from the edge accepting start until the edge leaving DONE
done  out  1  single-cycle pulse; results valid
div_by_zero  out  1  valid with done, held with results
quotient  out  WIDTH  held from done until the next accepted start
remainder  out  WIDTH  held from done until the next accepted start

Behaviour:
- Reset (reset=0, any time, including mid-operation): state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0. No partial result survives.
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE with start=1: latch op_signed, operand signs, |a| and |b| (magnitudes only when op_signed=1), and clear the partial remainder. Next state is CALC, or DONE if b==0. start is ignored in every other state.
- CALC, one iteration per cycle:
  - shift {rem, dividend} left 1;
  - trial = rem - divisor (WIDTH+1 bits);
  - if trial >= 0, rem = trial and quotient bit = 1;
  - counter increments.
  - After WIDTH iterations, go to SIGN.
- SIGN: if op_signed, negate the quotient when the sign of a differs from the sign of b, and negate the remainder when a was negative. Register the final outputs. Next state is DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the following cycle. Next state is IDLE. A start in that following IDLE cycle is accepted (back-to-back operation).
- Latency: done is high in the cycle after WIDTH+2 rising edges counted from the edge that sampled start (edge 0). For b==0, done is high after edge 1.
- Divide by zero:
  - quotient = all ones;
  - remainder = a, unmodified;
  - div_by_zero=1, cleared at the next accepted start.
- Signed overflow (a = most-negative, b = -1): quotient = most-negative, remainder = 0, no flag. This is the natural result of the magnitude datapath.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Inputs a, b and op_signed may change freely while busy without affecting the operation in flight.

Decomposition:
- Package divmod_pkg holds:
  - state enum {IDLE, CALC, SIGN, DONE};
  - localparam defaults for WIDTH;
  - a function that computes the magnitude of a signed value.
- One sub-module, divmod_dp, holds the registered shift/subtract datapath and the sign fix-up. It is controlled by load/step/fix enables and returns a trial-borrow flag.
- The FSM and counter stay in divmod_seq.

Test Plan:
- WIDTH=32, unsigned, a=100, b=7 -> quotient=14, remainder=2, div_by_zero=0; done exactly after edge 34; busy high edges 0..34.
- Signed, a=-7 (0xFFFFFFF9), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also a=7, b=-2 -> quotient=-3, remainder=1.
- a=5, b=0 (both modes) -> done after edge 1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. The next op 9/3 -> div_by_zero=0, quotient=3, remainder=0.
- Signed a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0, no flag. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Start 100/7, toggle start and change a/b while busy -> a single done with 14/2. Assert reset=0 at edge 10 of a new op -> all outputs 0 immediately (asynchronous); after release, 20/6 completes with quotient=3, remainder=2.
- WIDTH=8 instance, unsigned 200/13 -> quotient=15, remainder=5 after edge 10. Back-to-back start in the cycle after done is accepted.

Source files
------------

// File: rtl/divmod_pkg.sv
`default_nettype none
// ============================================================================
// divmod_pkg : shared state encoding and helpers for the sequential divider
// Revision 1.0
// ============================================================================
package divmod_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  // Operands are zero-extended to 64 bits by the caller; the low bits of the
  // result are the magnitude at the caller's width.
  function automatic logic [63:0] magnitude(input logic [63:0] value, input logic negative);
    return negative ? (~value + 64'd1) : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divmod_dp.sv
`default_nettype none
// ============================================================================
// divmod_dp : registered restoring shift/subtract datapath with sign fix-up
// Revision 1.0
// ============================================================================
module divmod_dp
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             sub_i,
  input  logic             fix_i,
  input  logic             op_signed_i,
  input  logic             b_zero_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             trial_borrow_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  assign a_neg = op_signed_i & a_i[WIDTH-1];
  assign b_neg = op_signed_i & b_i[WIDTH-1];

  // The partial remainder always stays below the divisor, so WIDTH+1 bits
  // hold the trial difference and its MSB is the borrow.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    if (load_i) begin
      rem_d  = '0;
      dvd_d  = WIDTH'(magnitude(64'(a_i), a_neg));
      dvs_d  = WIDTH'(magnitude(64'(b_i), b_neg));
      negq_d = a_neg ^ b_neg;
      negr_d = a_neg;
      dz_d   = b_zero_i;
      if (b_zero_i) begin
        quo_d = '1;
        rmd_d = a_i;
      end
    end else if (step_i) begin
      dvd_d = {dvd_q[WIDTH-2:0], sub_i};
      rem_d = sub_i ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end else if (fix_i) begin
      quo_d = negq_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
      rmd_d = negr_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rmd_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
    end
  end

  assign trial_borrow_o = trial[WIDTH];
  assign div_by_zero_o  = dz_q;
  assign quotient_o     = quo_q;
  assign remainder_o    = rmd_q;

endmodule
`default_nettype wire

// File: rtl/divmod_seq.sv
`default_nettype none
// ============================================================================
// divmod_seq : multi-cycle signed/unsigned divider with start/done handshake
// Revision 1.0
// ============================================================================
module divmod_seq
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic             b_zero;
  logic             load;
  logic             step;
  logic             fix;
  logic             trial_borrow;
  logic             last_iter;

  assign b_zero    = (b == '0);
  assign load      = (state_q == IDLE) && start;
  assign step      = (state_q == CALC);
  assign fix       = (state_q == SIGN);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  divmod_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .CLK            (CLK),
    .reset          (reset),
    .load_i         (load),
    .step_i         (step),
    .sub_i          (~trial_borrow),
    .fix_i          (fix),
    .op_signed_i    (op_signed),
    .b_zero_i       (b_zero),
    .a_i            (a),
    .b_i            (b),
    .trial_borrow_o (trial_borrow),
    .div_by_zero_o  (div_by_zero),
    .quotient_o     (quotient),
    .remainder_o    (remainder)
  );

  // done is raised on the edge leaving DONE, the same edge that drops busy,
  // so a new start can be accepted while done is high.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= b_zero ? DONE : CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) state_q <= SIGN;
        end
        SIGN: state_q <= DONE;
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_divmod_seq.sv
`default_nettype none
// tb_divmod_seq : vector table plus scoreboard checks for 32-bit and 8-bit dividers
module tb_divmod_seq;

  typedef struct {
    bit          w8;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
  } vec_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] q32, r32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  bit          sel = 1'b0;
  logic        busy_s, done_s, dz_s;
  logic [31:0] q_s, r_s;

  int checks = 0;
  int errors = 0;
  vec_t sb[$];
  vec_t tbl[14];
  vec_t t8[5];

  always #5 CLK = ~CLK;

  divmod_seq #(.WIDTH(32)) dut32 (
    .CLK(CLK), .reset(reset), .start(start32), .op_signed(sgn32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_by_zero(dz32), .quotient(q32), .remainder(r32)
  );

  divmod_seq #(.WIDTH(8)) dut8 (
    .CLK(CLK), .reset(reset), .start(start8), .op_signed(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_by_zero(dz8), .quotient(q8), .remainder(r8)
  );

  always_comb begin
    busy_s = sel ? busy8 : busy32;
    done_s = sel ? done8 : done32;
    dz_s   = sel ? dz8   : dz32;
    q_s    = sel ? {24'd0, q8} : q32;
    r_s    = sel ? {24'd0, r8} : r32;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic s, input logic [31:0] av,
                       input logic [31:0] bv, input logic st);
    if (w8) begin
      start8 = st; sgn8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start32 = st; sgn32 = s; a32 = av; b32 = bv;
    end
  endtask

  // Caller is positioned at a negedge; the following posedge is edge 0.
  task automatic start_op(input vec_t v);
    sel = v.w8;
    drive(v.w8, v.sgn, v.a, v.b, 1'b1);
    sb.push_back(v);
    @(negedge CLK);
    drive(v.w8, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    check("busy_after_start", {31'd0, busy_s}, 32'd1);
  endtask

  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    while (!done_s && lat < 80) begin
      if (noise) drive(sel, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      @(negedge CLK);
      lat++;
    end
    if (noise) drive(sel, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic finish_op(input int lat);
    vec_t e;
    int   exp_lat;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got done with no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    exp_lat = e.dz ? 1 : (e.w8 ? 10 : 34);
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_at_done", {31'd0, busy_s}, 32'd0);
    check("quotient", q_s, e.q);
    check("remainder", r_s, e.r);
    check("div_by_zero", {31'd0, dz_s}, {31'd0, e.dz});
  endtask

  task automatic do_vec(input vec_t v, input bit b2b, input bit noise);
    int lat;
    if (!b2b) @(negedge CLK);
    start_op(v);
    wait_done(noise, lat);
    finish_op(lat);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    tbl[4]  = '{1'b0, 1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};

    t8[0] = '{1'b1, 1'b0, 32'd200,  32'd13,  32'd15,  32'd5,   1'b0};
    t8[1] = '{1'b1, 1'b0, 32'd255,  32'd16,  32'd15,  32'd15,  1'b0};
    t8[2] = '{1'b1, 1'b1, 32'h80,   32'hFF,  32'h80,  32'd0,   1'b0};
    t8[3] = '{1'b1, 1'b1, 32'hF9,   32'd2,   32'hFD,  32'hFF,  1'b0};
    t8[4] = '{1'b1, 1'b1, 32'h85,   32'd0,   32'hFF,  32'h85,  1'b1};

    // Reset state of both instances
    repeat (2) @(negedge CLK);
    check("rst_busy32", {31'd0, busy32}, 32'd0);
    check("rst_done32", {31'd0, done32}, 32'd0);
    check("rst_dz32",   {31'd0, dz32},   32'd0);
    check("rst_q32", q32, 32'd0);
    check("rst_r32", r32, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_q8", {24'd0, q8}, 32'd0);
    check("rst_r8", {24'd0, r8}, 32'd0);
    reset = 1'b1;

    // Table vectors, back-to-back after the first
    for (int i = 0; i < 14; i++) do_vec(tbl[i], i != 0, 1'b0);

    // Noisy inputs while busy: one done only, with the originally sampled operands
    do_vec(tbl[0], 1'b0, 1'b1);
    @(negedge CLK);
    check("single_done", {31'd0, done32}, 32'd0);
    check("no_extra_start", {31'd0, busy32}, 32'd0);

    // Asynchronous reset in the middle of an operation
    @(negedge CLK);
    sel = 1'b0;
    drive(1'b0, 1'b0, 32'd20, 32'd6, 1'b1);
    @(negedge CLK);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (9) @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy32}, 32'd0);
    check("midrst_done", {31'd0, done32}, 32'd0);
    check("midrst_dz",   {31'd0, dz32},   32'd0);
    check("midrst_q", q32, 32'd0);
    check("midrst_r", r32, 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    do_vec('{1'b0, 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0}, 1'b0, 1'b0);

    // 8-bit instance, back-to-back after the first
    for (int i = 0; i < 5; i++) do_vec(t8[i], i != 0, 1'b0);

    // Random 32-bit operations against a native-arithmetic model
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      logic signed [31:0] sa, sbv;
      v.w8  = 1'b0;
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = $urandom >> $urandom_range(0, 31);
      if (v.b == '0) v.b = 32'd1;
      if (v.sgn && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 32'd3;
      v.dz = 1'b0;
      if (v.sgn) begin
        sa  = v.a;
        sbv = v.b;
        v.q = 32'(sa / sbv);
        v.r = 32'(sa % sbv);
      end else begin
        v.q = v.a / v.b;
        v.r = v.a % v.b;
      end
      do_vec(v, i[0], 1'b0);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending entries, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
